serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor. Computes diff = a - b, LSB first, one bit per clock, and returns the final borrow.
- Inverse-direction companion to the team's combinational half-adder tile. Each bit uses a full subtractor built from two half-subtractor cells.
- Sits behind the tile's ui_in switches: a on ui_in[3:0], b on ui_in[7:4]. Results drive uo_out.

---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/serial_subtractor_half_sub.sv | 13 +
 rtl/serial_subtractor.sv | 162 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding, default
// operand width and the bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  // One extra bit over clog2 keeps the counter clear of wrap for any legal WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_half_sub.sv
// Half-subtractor cell, the subtracting twin of the half-adder tile cell.
// Two of these plus an OR form one full-subtractor bit.
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bout
);

  assign d    = x ^ y;
  assign bout = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, diff = a - b, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             ovf_q, ovf_d;
`endif

  // Full subtractor for the current bit: a - b, then minus the running borrow.
  logic d_half, bout_half, d_bit, bout_bor, bor_next;

  half_sub u_hs_ab (
    .x   (a_sr_q[0]),
    .y   (b_sr_q[0]),
    .d   (d_half),
    .bout(bout_half)
  );

  half_sub u_hs_bor (
    .x   (d_half),
    .y   (bor_q),
    .d   (d_bit),
    .bout(bout_bor)
  );

  assign bor_next = bout_half | bout_bor;

  always_comb begin
    // NOTE: every _d gets a default here so no path through the case can infer a latch.
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bor_d    = bor_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          diff_d  = '0;
          cnt_d   = '0;
          bor_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          sign_a_d = a[WIDTH-1];
          sign_b_d = b[WIDTH-1];
          ovf_d    = 1'b0;
`endif
        end
      end

      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        bor_d  = bor_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          borrow_d = bor_next;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
`ifdef SERIAL_SUB_OVF_EN
          // d_bit on the last cycle is the sign bit of the result.
          ovf_d = (sign_a_q != sign_b_q) && (d_bit != sign_a_q);
`endif
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bor_q    <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bor_q    <= bor_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): expected results are queued
// at issue time and a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         b;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic [W-1:0] diff;
  logic         borrow_out, busy, done;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;
  int   n_issued = 0;
  int   cyc = 0;
  int   prev_cyc = 0;
  bit   have_prev = 1'b0;
  bit   b2b = 1'b0;
  exp_t exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .diff      (diff),
    .borrow_out(borrow_out),
    .busy      (busy),
    .done      (done)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.d = W'((x - y) & 4'hF);
    e.b = (x < y);
    e.o = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("diff", 32'(diff), 32'(e.d));
        check("borrow_out", 32'(borrow_out), 32'(e.b));
        check("busy_at_done", 32'(busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(e.o));
`endif
      end
      if (b2b) begin
        if (have_prev) check("done_spacing", 32'(cyc - prev_cyc), 32'd6);
        prev_cyc  = cyc;
        have_prev = 1'b1;
      end
    end
  end

  // Drive one start pulse while the DUT is idle; returns after the accepting edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    @(posedge clk); #1;
    start = 1'b1; a = x; b = y;
    if (push) begin
      exp_q.push_back(model(x, y));
      n_issued++;
    end
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom_range(0, 15));
    b = W'($urandom_range(0, 15));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    logic [W-1:0] x, y;
    va = '{4'd9, 4'd3, 4'd0, 4'd15, 4'd7, 4'd2, 4'd0, 4'd15};
    vb = '{4'd3, 4'd9, 4'd0, 4'd15, 4'd8, 4'd1, 4'd15, 4'd0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 9 - 3 with cycle-accurate busy/done window.
    issue(4'd9, 4'd3, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("busy_c%0d", i), 32'(busy), 32'd1);
      check($sformatf("nodone_c%0d", i), 32'(done), 32'd0);
    end
    @(negedge clk);
    check("done_c5", 32'(done), 32'd1);
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);

    // Remaining directed vectors.
    for (int k = 1; k < 8; k++) begin
      issue(va[k], vb[k], 1'b1);
      wait_done();
    end

    // Start re-pulsed mid-operation with a=1, b=1 must be ignored.
    issue(4'd9, 4'd3, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; a = 4'd1; b = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (8) @(posedge clk);

    // Reset during an operation aborts it without a done pulse.
    issue(4'd5, 4'd2, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    issue(4'd12, 4'd5, 1'b1);
    wait_done();

    // Back-to-back with start held high; spacing checked by the monitor.
    repeat (3) @(posedge clk);
    #1;
    b2b = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 200; k++) begin
      x = W'($urandom_range(0, 15));
      y = W'($urandom_range(0, 15));
      a = x; b = y;
      exp_q.push_back(model(x, y));
      n_issued++;
      wait_done();
      if (k == 199) start = 1'b0;
      @(posedge clk); #1;
    end
    b2b = 1'b0;

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_issued));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
